// File: rtl/mxu_result_drain_pkg.sv
// rtl/mxu_result_drain_pkg.sv - mxu_pkg: drain FSM states, default sizes and the lane saturation helper
package mxu_pkg;

  localparam int MXU_N_COLS_DEF = 8;
  localparam int MXU_OUT_W_DEF  = 32;
  // Lanes are sign-extended to this width before clamping.
  localparam int MXU_SAT_IN_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DRAIN   = 2'd3
  } mxu_drain_state_e;

  // Signed clamp of val into out_w bits; the extra MSB of the result flags that a clamp happened.
  function automatic logic [MXU_SAT_IN_W:0] mxu_saturate(input logic signed [MXU_SAT_IN_W-1:0] val,
                                                         input int out_w);
    logic signed [MXU_SAT_IN_W-1:0] hi;
    logic signed [MXU_SAT_IN_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (val > hi) begin
      return {1'b1, hi};
    end else if (val < lo) begin
      return {1'b1, lo};
    end
    return {1'b0, val};
  endfunction

endpackage

// File: rtl/mxu_result_drain_if.sv
// rtl/mxu_result_drain_if.sv - aligned result vector stream between the drain and its sink
interface mxu_result_drain_if #(
  parameter int N_COLS = mxu_pkg::MXU_N_COLS_DEF,
  parameter int OUT_W  = mxu_pkg::MXU_OUT_W_DEF
);

  logic [N_COLS*OUT_W-1:0] out_data_o;
  logic                    out_valid_o;
  logic                    out_ready_i;

  modport master (
    output out_data_o,
    output out_valid_o,
    input  out_ready_i
  );

  modport slave (
    input  out_data_o,
    input  out_valid_o,
    output out_ready_i
  );

endinterface

// File: rtl/mxu_result_drain_fifo.sv
// rtl/mxu_result_drain_fifo.sv - mxu_vec_fifo: show-ahead synchronous FIFO holding aligned result vectors
module mxu_vec_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mxu_result_drain.sv
// rtl/mxu_result_drain.sv - deskews MXU bottom-row sums into aligned vectors; MXU_DRAIN_SAT_EN enables lane saturation
module mxu_result_drain import mxu_pkg::*; #(
  parameter int N_COLS     = MXU_N_COLS_DEF,
  parameter int bit_width  = 64,
  parameter int OUT_W      = MXU_OUT_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_i,
  input  logic [15:0]                 n_vec_i,
  input  logic                        col_valid_i,
  input  logic [N_COLS*bit_width-1:0] res_i,
  output logic                        ce_o,
  mxu_result_drain_if.master          out_if,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        sat_o
);

  localparam int CW  = $clog2(N_COLS) + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(N_COLS - 2);

  mxu_drain_state_e state_q, state_d;
  logic [15:0]      n_vec_q, n_vec_d;
  logic [15:0]      acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]    flush_cnt_q, flush_cnt_d;
  logic             run_q;

  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             unused_fifo_full;
  logic [FCW-1:0]   fifo_count;

  logic [N_COLS-2:0]       vld_q;
  logic [bit_width-1:0]    aligned [N_COLS];
  logic [N_COLS*OUT_W-1:0] push_data;

  // The array only advances while the FIFO can absorb every in-flight vector.
  assign ce_o   = run_q & (fifo_count < FCW'(FIFO_DEPTH));
  assign accept = (state_q == ST_COLLECT) & col_valid_i & ce_o;
  assign push   = vld_q[N_COLS-2] & ce_o;
  assign pop    = out_if.out_valid_o & out_if.out_ready_i;

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DRAIN) & fifo_empty;

  // Holds ce_o low while reset is applied and releases it once out of reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Valid tag shift register travelling alongside lane 0 of each accepted vector
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
    end else if (ce_o) begin
      vld_q[0] <= accept;
      for (int s = 1; s < N_COLS - 1; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  for (genvar c = 0; c < N_COLS; c++) begin : g_lane
    logic [bit_width-1:0] lane_in;
    assign lane_in = res_i[c*bit_width +: bit_width];

    if (c < N_COLS - 1) begin : g_dly
      localparam int STAGES = N_COLS - 1 - c;
      logic [bit_width-1:0] sr_q [STAGES];

      // Lane delay line, frozen together with the array when ce_o is low
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int s = 0; s < STAGES; s++) begin
            sr_q[s] <= '0;
          end
        end else if (ce_o) begin
          sr_q[0] <= lane_in;
          for (int s = 1; s < STAGES; s++) begin
            sr_q[s] <= sr_q[s-1];
          end
        end
      end

      assign aligned[c] = sr_q[STAGES-1];
    end else begin : g_nodly
      assign aligned[c] = lane_in;
    end

`ifdef MXU_DRAIN_SAT_EN
    logic signed [MXU_SAT_IN_W-1:0] lane_ext;
    logic [MXU_SAT_IN_W:0]          lane_sat;
    logic                           unused_sat_hi;

    if (bit_width < MXU_SAT_IN_W) begin : g_ext
      assign lane_ext = {{(MXU_SAT_IN_W - bit_width){aligned[c][bit_width-1]}}, aligned[c]};
    end else begin : g_full
      assign lane_ext = aligned[c][MXU_SAT_IN_W-1:0];
    end

    assign lane_sat                     = mxu_saturate(lane_ext, OUT_W);
    assign push_data[c*OUT_W +: OUT_W] = lane_sat[OUT_W-1:0];
    assign unused_sat_hi               = ^lane_sat[MXU_SAT_IN_W-1:OUT_W];
`else
    assign push_data[c*OUT_W +: OUT_W] = aligned[c][OUT_W-1:0];
    if (OUT_W < bit_width) begin : g_drop
      logic unused_lane_hi;
      assign unused_lane_hi = ^aligned[c][bit_width-1:OUT_W];
    end
`endif
  end

`ifdef MXU_DRAIN_SAT_EN
  logic [N_COLS-1:0] lane_clamp;
  logic              sat_q, sat_d;

  for (genvar c = 0; c < N_COLS; c++) begin : g_clamp
    assign lane_clamp[c] = g_lane[c].lane_sat[MXU_SAT_IN_W];
  end

  // Sticky clamp flag for the current job, cleared when a new job starts
  always_comb begin
    sat_d = sat_q;
    if ((state_q == ST_IDLE) && start_i) begin
      sat_d = 1'b0;
    end else if (push && (|lane_clamp)) begin
      sat_d = 1'b1;
    end
  end

  // Saturation flag register
  always_ff @(posedge clk) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`else
  assign sat_o = 1'b0;
`endif

  mxu_vec_fifo #(
    .WIDTH (N_COLS*OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (out_if.out_data_o),
    .count_o (fifo_count),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_if.out_valid_o = ~fifo_empty;

  // Job sequencing: collect n_vec accepts, flush the skew pipeline, then wait for the FIFO to empty
  always_comb begin
    state_d     = state_q;
    n_vec_d     = n_vec_q;
    acc_cnt_d   = acc_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          n_vec_d     = n_vec_i;
          acc_cnt_d   = '0;
          flush_cnt_d = '0;
          state_d     = (n_vec_i == 16'd0) ? ST_DRAIN : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + 16'd1;
          if (acc_cnt_d == n_vec_q) begin
            flush_cnt_d = '0;
            state_d     = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (ce_o) begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and job counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      n_vec_q     <= '0;
      acc_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      n_vec_q     <= n_vec_d;
      acc_cnt_q   <= acc_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_mxu_result_drain.sv
// tb/tb_mxu_result_drain.sv - scoreboard bench for mxu_result_drain with a ce-aware skewed array model
`timescale 1ns/1ps
module tb_mxu_result_drain;

  localparam int N_COLS = 4;
  localparam int BW     = 64;
  localparam int OUT_W  = 32;
  localparam int DEPTH  = 4;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   start_i;
  logic [15:0]            n_vec_i;
  logic                   col_valid_i;
  logic [N_COLS*BW-1:0]   res_i;
  logic                   ce_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   sat_o;

  int checks = 0;
  int errors = 0;
  logic [N_COLS*OUT_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  mxu_result_drain_if #(.N_COLS(N_COLS), .OUT_W(OUT_W)) out_if ();

  mxu_result_drain #(
    .N_COLS(N_COLS), .bit_width(BW), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(rstn), .start_i(start_i), .n_vec_i(n_vec_i),
    .col_valid_i(col_valid_i), .res_i(res_i), .ce_o(ce_o), .out_if(out_if),
    .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o)
  );

  function automatic logic [63:0] lane_val(input int pat, input int k, input int c);
    if (pat == 1) begin
      case (c)
        0:       return 64'h0000_0100_0000_0000 + 64'(k);
        1:       return 64'hFFFF_FF00_0000_0000;
        2:       return 64'd5 + 64'(k);
        default: return 64'hFFFF_FFFF_FFFF_FFFB;
      endcase
    end
    return 64'(pat * 256 + 16 * k + c);
  endfunction

  function automatic logic [OUT_W-1:0] exp_lane(input logic [63:0] v);
`ifdef MXU_DRAIN_SAT_EN
    logic signed [63:0] s;
    s = $signed(v);
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return v[OUT_W-1:0];
  endfunction

  function automatic logic [N_COLS*OUT_W-1:0] exp_vec(input int pat, input int k);
    logic [N_COLS*OUT_W-1:0] v;
    for (int c = 0; c < N_COLS; c++) v[c*OUT_W +: OUT_W] = exp_lane(lane_val(pat, k, c));
    return v;
  endfunction

  // Array model: at step j lane c carries vector j-c; nothing moves unless ce_o was high.
  task automatic drive_step(input int j, input int n, input int pat);
    col_valid_i = (j < n);
    for (int c = 0; c < N_COLS; c++) begin
      if ((j - c >= 0) && (j - c < n)) res_i[c*BW +: BW] = lane_val(pat, j - c, c);
      else res_i[c*BW +: BW] = '0;
    end
  endtask

  task automatic run_job(input int n, input int pat, input bit hold_ready,
                         output int first_lat, output int done_gap, output int ce_hi_before_stall);
    int j, idx, beats, stall_cycles, first_acc, first_vld, last_hs, done_idx, ce_cnt;
    bit ce_s;
    logic [N_COLS*OUT_W-1:0] exp;
    idx = 0; beats = 0; stall_cycles = 0; first_acc = -1; first_vld = -1;
    last_hs = 0; done_idx = -1; ce_cnt = 0; ce_hi_before_stall = -1; j = 0;
    out_if.out_ready_i = !hold_ready;
    start_i = 1'b1;
    n_vec_i = 16'(n);
    @(posedge clk); #1; idx++;
    start_i = 1'b0;
    checks++;
    if (sat_o !== 1'b0) begin errors++; $display("FAIL sat_clear_on_start: got %b want 0", sat_o); end
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy_o); end
    while (done_idx < 0 && idx < 400) begin
      if (j < n + N_COLS - 1) drive_step(j, n, pat);
      else drive_step(n + N_COLS, n, pat);
      if (ce_o && j < n) begin
        exp_q.push_back(exp_vec(pat, j));
        if (first_acc < 0) first_acc = idx;
      end
      if (hold_ready && !out_if.out_ready_i) begin
        if (!ce_o) begin
          if (ce_hi_before_stall < 0) ce_hi_before_stall = ce_cnt;
          stall_cycles++;
          if (stall_cycles == 4) out_if.out_ready_i = 1'b1;
        end
      end
      if (out_if.out_valid_o && first_vld < 0) first_vld = idx;
      if (out_if.out_valid_o && out_if.out_ready_i) begin
        beats++;
        last_hs = idx;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h want no beat", out_if.out_data_o);
        end else begin
          exp = exp_q.pop_front();
          if (out_if.out_data_o !== exp) begin
            errors++;
            $display("FAIL beat_data: got %h want %h", out_if.out_data_o, exp);
          end
        end
      end
      if (done_o) done_idx = idx;
      ce_s = ce_o;
      if (ce_o) ce_cnt++;
      @(posedge clk); #1; idx++;
      if (ce_s && j < n + N_COLS - 1) j++;
    end
    checks++;
    if (done_idx < 0) begin errors++; $display("FAIL job_timeout: got no done want done within 400 cycles"); end
    checks++;
    if (beats != n) begin errors++; $display("FAIL beat_count: got %0d want %0d", beats, n); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL done_pulse_end: got done=%b busy=%b want 0 0", done_o, busy_o);
    end
    exp_q.delete();
    out_if.out_ready_i = 1'b1;
    first_lat = (first_vld >= 0 && first_acc >= 0) ? first_vld - first_acc : -1;
    done_gap  = done_idx - last_hs;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_i = 1'b0; n_vec_i = '0; col_valid_i = 1'b0; res_i = '0;
    out_if.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ce_o, out_if.out_valid_o, busy_o, done_o, sat_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {ce_o, out_if.out_valid_o, busy_o, done_o, sat_o});
    end
    checks++;
    if (out_if.out_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_if.out_data_o); end
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ce_o !== 1'b1) begin errors++; $display("FAIL ce_after_reset: got %b want 1", ce_o); end
  endtask

  task automatic test_basic();
    int lat, gap, ceh;
    run_job(3, 0, 1'b0, lat, gap, ceh);
    checks++;
    if (lat != N_COLS) begin errors++; $display("FAIL first_beat_latency: got %0d want %0d", lat, N_COLS); end
    checks++;
    if (gap != 1) begin errors++; $display("FAIL done_after_last_beat: got %0d want 1", gap); end
    checks++;
    if (sat_o !== 1'b0) begin errors++; $display("FAIL sat_small_values: got %b want 0", sat_o); end
  endtask

  task automatic test_backpressure();
    int lat, gap, ceh;
    run_job(8, 2, 1'b1, lat, gap, ceh);
    checks++;
    if (ceh != DEPTH + N_COLS - 1) begin
      errors++; $display("FAIL ce_fall_point: got %0d want %0d", ceh, DEPTH + N_COLS - 1);
    end
  endtask

  task automatic test_zero_job();
    int lat, gap, ceh;
    run_job(0, 0, 1'b0, lat, gap, ceh);
    checks++;
    if (gap != 1) begin errors++; $display("FAIL zero_job_done: got %0d want 1", gap); end
  endtask

  task automatic test_saturation();
    int lat, gap, ceh;
    bit exp_sat;
`ifdef MXU_DRAIN_SAT_EN
    exp_sat = 1'b1;
`else
    exp_sat = 1'b0;
`endif
    run_job(2, 1, 1'b0, lat, gap, ceh);
    checks++;
    if (sat_o !== exp_sat) begin errors++; $display("FAIL sat_flag: got %b want %b", sat_o, exp_sat); end
    run_job(2, 4, 1'b0, lat, gap, ceh);
  endtask

  task automatic test_reset_midjob();
    int lat, gap, ceh;
    start_i = 1'b1;
    n_vec_i = 16'd6;
    @(posedge clk); #1;
    start_i = 1'b0;
    drive_step(0, 6, 5);
    @(posedge clk); #1;
    drive_step(1, 6, 5);
    rstn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ce_o, out_if.out_valid_o, busy_o, done_o, sat_o} !== 5'b0) begin
      errors++; $display("FAIL midjob_reset_flags: got %b want 00000", {ce_o, out_if.out_valid_o, busy_o, done_o, sat_o});
    end
    checks++;
    if (out_if.out_data_o !== '0) begin errors++; $display("FAIL midjob_reset_data: got %h want 0", out_if.out_data_o); end
    rstn = 1'b1;
    drive_step(100, 0, 0);
    @(posedge clk); #1;
    run_job(3, 6, 1'b0, lat, gap, ceh);
    checks++;
    if (lat != N_COLS) begin errors++; $display("FAIL post_reset_latency: got %0d want %0d", lat, N_COLS); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_job();
    test_saturation();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mxu_result_drain.md
# mxu_result_drain

Collects partial sums leaving the bottom row of the MXU systolic array, removes the per-column skew introduced by the diagonal data wavefront, and delivers one aligned result vector per beat on a valid/ready stream. It is the output-side counterpart of the array's skewed input feed. It back-pressures the array through `ce_o`, which drives the cell `ce` of the whole array.

## Interface
Parameters:
- `N_COLS`, 8: array columns, i.e. lanes per vector.
- `bit_width`, 64: lane width of `res_mac_n` arriving from the array.
- `OUT_W`, 32: lane width on the output stream.
- `FIFO_DEPTH`, 4: aligned-vector FIFO entries; must be a power of two and at least 2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset.
- `start_i` in 1: one-cycle pulse that begins a drain job; sampled only in IDLE.
- `n_vec_i` in 16: number of vectors in the job, sampled with `start_i`.
- `col_valid_i` in 1: column 0 of the bottom row carries a valid result this cycle.
- `res_i` in N_COLS*bit_width: bottom-row `res_mac_n` values; lane c is at `[c*bit_width +: bit_width]`.
- `ce_o` out 1: array advance enable.
- `out_data_o` out N_COLS*OUT_W: aligned vector, lane c at `[c*OUT_W +: OUT_W]`.
- `out_valid_o` out 1: output beat valid.
- `out_ready_i` in 1: output sink ready.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse at job completion.
- `sat_o` out 1: sticky per-job saturation flag.

## Operation
- FSM states are IDLE, COLLECT, FLUSH, DRAIN.
  - IDLE to COLLECT on `start_i`. If `n_vec_i`==0, go IDLE to DRAIN directly.
  - COLLECT: every cycle with `col_valid_i & ce_o` is an accepted vector. When the accepted count reaches `n_vec`, go to FLUSH.
  - FLUSH: count N_COLS-1 cycles with `ce_o` high, then go to DRAIN.
  - DRAIN: when the FIFO is empty, pulse `done_o` and return to IDLE.
- `col_valid_i` is ignored outside COLLECT. `start_i` is ignored while `busy_o` is high.
- Deskew:
  - Lane c of a vector arrives c ce-qualified cycles after lane 0.
  - Lane c is delayed by a shift register of N_COLS-1-c stages, clocked only when `ce_o`=1. Lane N_COLS-1 has no delay stage.
  - A parallel valid shift register of N_COLS-1 stages tracks accepted vectors.
  - An aligned vector is pushed into the FIFO when the valid shift register's output is 1 and `ce_o`=1.
- Back-pressure:
  - `ce_o` = (FIFO count < FIFO_DEPTH), taken from registered state only. There is no combinational path from `out_ready_i`.
  - When `ce_o`=0 the deskew and valid registers hold their contents, so no in-flight data is lost.
- Output: FIFO head drives `out_data_o` and `out_valid_o`. The head is popped on `out_valid_o & out_ready_i`. Push and pop in the same cycle leave the count unchanged.
- Lane conversion from bit_width to OUT_W is described under Configuration.
- Reset values: `ce_o`=0 during reset and 1 afterwards, because the FIFO is empty. `out_valid_o`, `busy_o`, `done_o`, and `sat_o` are 0. `out_data_o` is 0. FSM is in IDLE. All counters, shift registers, and the FIFO are cleared.
- Reset asserted mid-job discards every in-flight vector and every FIFO entry. No `done_o` pulse is produced.

## Timing
- With `ce_o` high continuously and the sink ready, the vector accepted at edge t appears on `out_valid_o` after edge t+N_COLS.
- Throughput is one vector per cycle.
- `done_o` is earliest 1 cycle after the last beat handshake, and 1 cycle after `start_i` when `n_vec_i`=0.
- `sat_o` is cleared on job start and is valid until the next `start_i`.

## Configuration
- `MXU_DRAIN_SAT_EN` defined:
  - Each lane is signed-saturated from bit_width to OUT_W bits: clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - `sat_o` is set when any clamp occurs on a pushed vector.
  - Saturation is applied at FIFO push.
- `MXU_DRAIN_SAT_EN` undefined:
  - Each lane takes bits [OUT_W-1:0].
  - `sat_o` is tied to 0.

## Structure
- Shared package `mxu_pkg` holds:
  - the FSM state typedef;
  - `MXU_N_COLS_DEF` and `MXU_OUT_W_DEF`;
  - the saturate function.
- Natural sub-module: `mxu_vec_fifo`, a synchronous FIFO of parameterized width and depth with count, push, pop, full, and empty.
- The deskew shift registers stay in the top level, generated per lane.

## Test plan
- N_COLS=4, `n_vec`=3, skewed lanes fed in order (lane c of vector k = 16*k+c), sink always ready -> three beats {0,1,2,3}, {16,17,18,19}, {32,33,34,35}; first beat arrives 4 cycles after the first accept; `done_o` follows.
- `out_ready_i` held low for the whole job, `n_vec`=8, FIFO_DEPTH=4 -> `ce_o` falls after the 4th push; releasing ready yields all 8 vectors intact and in order.
- `n_vec_i`=0 -> `done_o` one cycle after `start_i`; `out_valid_o` never asserted.
- `MXU_DRAIN_SAT_EN` defined, lane value 2^40 with OUT_W=32 -> lane output 0x7FFFFFFF and `sat_o`=1. Undefined -> lane output 0 and `sat_o`=0.
- Reset pulled low at the 2nd accept of a 6-vector job -> all outputs go to their reset values the next cycle, and a new job afterwards runs cleanly.
